ft245_sync_dev: RTL
===================

# ft245_sync_dev

- Synthesizable device-side emulator of the FT232H synchronous 245 FIFO interface: the FTDI chip's end of the bus that `usb_axi` drives as a master.
- Holds an RX FIFO (bytes toward the FPGA, supplied by a host byte stream) and a TX FIFO (bytes written by the FPGA, drained to a host byte stream).
- Drives `usb_rxf_n`/`usb_txe_n`/data with FT232H semantics; used in benches and on-board self-test in place of the real chip.

## Interface
- `RX_DEPTH`, 16, RX FIFO depth in bytes; power of 2, ≥4.
- `TX_DEPTH`, 16, TX FIFO depth in bytes; power of 2, ≥4.
- `usb_clk_60m`  in  1  sole clock; all logic on rising edge.
- `sys_rst_n`  in  1  asynchronous active-low reset.
- `usb_oe_n`  in  1  FPGA output-enable request (low = device drives data).
- `usb_rd_n`  in  1  FPGA read strobe, active low.
- `usb_wr_n`  in  1  FPGA write strobe, active low.
- `usb_data_i`  in  8  bus value driven by FPGA (write data).
- `usb_data_o`  out  8  bus value driven by device (read data).
- `usb_data_oe`  out  1  device drives bus; the top level builds the tristate.
- `usb_rxf_n`  out  1  low = RX FIFO holds data.
- `usb_txe_n`  out  1  low = TX FIFO has space.
- `host_tx_valid` / `host_tx_ready` / `host_tx_data`  in/out/in  1/1/8  byte stream pushed into the RX FIFO.
- `host_rx_valid` / `host_rx_ready` / `host_rx_data`  out/in/out  1/1/8  byte stream popped from the TX FIFO.
- `err_o`  out  3  sticky errors: [0] read while `usb_rxf_n` high, [1] write while `usb_txe_n` high, [2] `usb_wr_n` low while `usb_data_oe` high.
- `err_clr`  in  1  clears `err_o` (set on the same edge wins).

## Operation
- Both FIFOs are first-word-fall-through.
- `usb_data_o` always shows the RX FIFO head; 0x00 when the FIFO is empty.
- `host_tx_ready` = RX FIFO not full.
- `host_rx_valid` = TX FIFO not empty.
- `host_rx_data` = TX FIFO head.
- **RX pop:** on an edge where `usb_oe_n`=0, `usb_rd_n`=0 and `usb_rxf_n`=0, the head is consumed.
- Consecutive cycles of `usb_rd_n`=0 stream one byte per clock.
- **Invalid read:** a read strobe with `usb_rxf_n`=1 is ignored and sets `err_o[0]`.
- **TX push:** on an edge where `usb_wr_n`=0 and `usb_txe_n`=0, `usb_data_i` is written to the TX FIFO.
- **Invalid write:** a write strobe with `usb_txe_n`=1 drops the byte and sets `err_o[1]`.
- **Bus conflict:** `usb_wr_n`=0 while `usb_data_oe`=1 sets `err_o[2]`; the write is still processed per the rules above.
- **Simultaneous events:**
  - Host push and FPGA pop on the same edge both occur; RX count is unchanged.
  - Same rule for FPGA push and host pop on the TX FIFO.
  - A FIFO that is full at an edge accepts a push on that edge only if it also pops on that edge.
- **Pointers and counts:**
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Counts are log2(DEPTH)+1 bits.
- **Reset mid-transfer:** reset empties both FIFOs immediately; in-flight strobes are discarded.

## Timing
- **Reset values:**
  - `usb_rxf_n`=1, `usb_txe_n`=0, `usb_data_oe`=0, `usb_data_o`=0x00.
  - `host_tx_ready`=1, `host_rx_valid`=0, `host_rx_data`=0x00, `err_o`=0.
- **`usb_rxf_n` is registered:**
  - `usb_rxf_n` <= (next RX count == 0).
  - It rises on the edge that pops the last byte.
  - It falls one clock after the host push that fills an empty FIFO.
- **`usb_txe_n` is registered:**
  - `usb_txe_n` <= (next TX count == TX_DEPTH).
  - It rises on the edge that fills the FIFO.
- **`usb_data_oe` is registered:** `usb_data_oe` <= !`usb_oe_n`.
  - This gives one clock of turnaround after the `usb_oe_n` fall.
  - The same one clock applies after the `usb_oe_n` rise.
- Read latency: the head is valid while `usb_rxf_n`=0. The next byte appears on `usb_data_o` the cycle after a pop edge.
- Host ports follow valid/ready; a transfer occurs on an edge where both are high.

## Configuration
- **`FT245_LOOPBACK_EN` defined:**
  - Bytes accepted via `usb_wr_n` are pushed directly into the RX FIFO; the TX FIFO is not instantiated.
  - `usb_txe_n` reflects RX FIFO space (next RX count == RX_DEPTH).
  - `host_tx_ready`=0, `host_rx_valid`=0, `host_rx_data`=0x00.
  - A pop on the same edge as a loopback push follows the simultaneous-event rule.
- **Undefined:** the two FIFOs are independent, as described above.

## Test plan
- **Reset values:** after reset, `usb_rxf_n`=1, `usb_txe_n`=0, `usb_data_oe`=0, `err_o`=0.
- **Host push to FPGA read:** push host bytes 0x01..0x04 → `usb_rxf_n` falls one clock after the first push. With `usb_oe_n` low and then `usb_rd_n` low for 4 cycles, `usb_data_o` reads 01, 02, 03, 04. `usb_rxf_n` rises on the 4th pop edge. `err_o`=0.
- **TX full and host drain:**
  - FPGA writes 16 bytes 0xA0..0xAF → `usb_txe_n`=1 after the 16th.
  - A 17th write (0xFF) sets `err_o[1]` and is dropped.
  - Host drains 0xA0..0xAF in order.
  - `usb_txe_n`=0 one clock after the first pop.
- **Full-boundary and error handling:**
  - RX FIFO full (16 bytes): host push and FPGA pop on the same edge → count stays 16, and the new byte is read last after wrap-around.
  - `usb_rd_n` low with `usb_rxf_n` high → `err_o[0]`=1.
  - `err_clr` → `err_o`=0.
- **Reset mid-transfer:** reset asserted during a 4-byte read burst after 2 pops → `usb_rxf_n`=1 and FIFOs empty. After release, a fresh push of 0x55 reads back as 0x55.
- **Loopback (with `FT245_LOOPBACK_EN`):** FPGA writes 0x11, 0x22 → `usb_rxf_n` falls, then reads return 0x11, 0x22. `host_rx_valid` stays 0.

Source files
------------

// File: rtl/ft245_sync_dev_if.sv
// FT232H synchronous 245 FIFO bus between the FPGA (master) and the FTDI device (slave).
interface ft245_sync_dev_if;
    logic       usb_oe_n;
    logic       usb_rd_n;
    logic       usb_wr_n;
    logic [7:0] usb_data_i;
    logic [7:0] usb_data_o;
    logic       usb_data_oe;
    logic       usb_rxf_n;
    logic       usb_txe_n;

    modport master (
        output usb_oe_n, usb_rd_n, usb_wr_n, usb_data_i,
        input  usb_data_o, usb_data_oe, usb_rxf_n, usb_txe_n
    );

    modport slave (
        input  usb_oe_n, usb_rd_n, usb_wr_n, usb_data_i,
        output usb_data_o, usb_data_oe, usb_rxf_n, usb_txe_n
    );
endinterface

// File: rtl/ft245_sync_dev.sv
// Device-side FT232H sync-245 emulator: host byte streams <-> RX/TX FWFT FIFOs <-> usb_* bus.
// Define FT245_LOOPBACK_EN to push FPGA writes straight into the RX FIFO (TX FIFO removed).
module ft245_sync_dev #(
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic             usb_clk_60m,
    input  logic             sys_rst_n,
    ft245_sync_dev_if.slave  bus,
    input  logic             host_tx_valid,
    output logic             host_tx_ready,
    input  logic [7:0]       host_tx_data,
    output logic             host_rx_valid,
    input  logic             host_rx_ready,
    output logic [7:0]       host_rx_data,
    output logic [2:0]       err_o,
    input  logic             err_clr
);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [RX_AW:0] RX_FULL = (RX_AW+1)'(RX_DEPTH);

    logic [7:0]       rx_mem_q [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
    logic [RX_AW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
    logic [RX_AW:0]   rx_count_q, rx_count_d;
    logic             rx_push, rx_pop;
    logic [7:0]       rx_push_data;
    logic             rxf_n_q, rxf_n_d;
    logic             txe_n_q, txe_n_d;
    logic             data_oe_q, data_oe_d;
    logic [2:0]       err_q, err_d;
    logic             wr_strobe, wr_accept;

    assign rx_pop    = !bus.usb_oe_n && !bus.usb_rd_n && !rxf_n_q;
    assign wr_strobe = !bus.usb_wr_n;
    assign wr_accept = wr_strobe && !txe_n_q;

`ifdef FT245_LOOPBACK_EN
    logic unused_host;
    assign unused_host   = ^{host_tx_valid, host_tx_data, host_rx_ready};
    assign rx_push       = wr_accept;
    assign rx_push_data  = bus.usb_data_i;
    assign host_tx_ready = 1'b0;
    assign host_rx_valid = 1'b0;
    assign host_rx_data  = 8'h00;
    // In loopback the FPGA's write space is the RX FIFO's space.
    assign txe_n_d       = (rx_count_d == RX_FULL);
`else
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL = (TX_AW+1)'(TX_DEPTH);

    logic [7:0]       tx_mem_q [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
    logic [TX_AW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
    logic [TX_AW:0]   tx_count_q, tx_count_d;
    logic             tx_push, tx_pop;

    // A full RX FIFO still takes a host byte when the FPGA pops on the same edge.
    assign host_tx_ready = (rx_count_q != RX_FULL) || rx_pop;
    assign rx_push       = host_tx_valid && host_tx_ready;
    assign rx_push_data  = host_tx_data;
    assign tx_push       = wr_accept;
    assign tx_pop        = host_rx_valid && host_rx_ready;
    assign host_rx_valid = (tx_count_q != '0);
    assign host_rx_data  = host_rx_valid ? tx_mem_q[tx_rd_ptr_q] : 8'h00;

    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q + TX_AW'(tx_push);
        tx_rd_ptr_d = tx_rd_ptr_q + TX_AW'(tx_pop);
        tx_count_d  = tx_count_q + (TX_AW+1)'(tx_push) - (TX_AW+1)'(tx_pop);
        txe_n_d     = (tx_count_d == TX_FULL);
    end

    always_ff @(posedge usb_clk_60m) begin
        if (tx_push) begin
            tx_mem_q[tx_wr_ptr_q] <= bus.usb_data_i;
        end
    end

    always_ff @(posedge usb_clk_60m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_count_q  <= '0;
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_count_q  <= tx_count_d;
        end
    end
`endif

    always_comb begin
        rx_wr_ptr_d = rx_wr_ptr_q + RX_AW'(rx_push);
        rx_rd_ptr_d = rx_rd_ptr_q + RX_AW'(rx_pop);
        rx_count_d  = rx_count_q + (RX_AW+1)'(rx_push) - (RX_AW+1)'(rx_pop);
        rxf_n_d     = (rx_count_d == '0);
        data_oe_d   = !bus.usb_oe_n;
        // Clear first so a fault on the clearing edge still latches.
        err_d = err_clr ? 3'b000 : err_q;
        if (!bus.usb_rd_n && rxf_n_q) err_d[0] = 1'b1;
        if (wr_strobe && txe_n_q)     err_d[1] = 1'b1;
        if (wr_strobe && data_oe_q)   err_d[2] = 1'b1;
    end

    always_ff @(posedge usb_clk_60m) begin
        if (rx_push) begin
            rx_mem_q[rx_wr_ptr_q] <= rx_push_data;
        end
    end

    always_ff @(posedge usb_clk_60m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_count_q  <= '0;
            rxf_n_q     <= 1'b1;
            txe_n_q     <= 1'b0;
            data_oe_q   <= 1'b0;
            err_q       <= 3'b000;
        end else begin
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_count_q  <= rx_count_d;
            rxf_n_q     <= rxf_n_d;
            txe_n_q     <= txe_n_d;
            data_oe_q   <= data_oe_d;
            err_q       <= err_d;
        end
    end

    assign bus.usb_rxf_n   = rxf_n_q;
    assign bus.usb_txe_n   = txe_n_q;
    assign bus.usb_data_oe = data_oe_q;
    assign bus.usb_data_o  = (rx_count_q == '0) ? 8'h00 : rx_mem_q[rx_rd_ptr_q];
    assign err_o           = err_q;
endmodule
